// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-ported memory: D has priority, I has a starvation guard,
// and every access is bounded by a hit timeout. One access is in flight at a time.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_mask,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic        m_read,
    output logic        m_write,
    output logic [2:0]  m_mask,
    input  logic [31:0] m_rdata,
    input  logic        m_hit,
    output logic        busy,
    output logic        timeout_err
);

    localparam int unsigned WaitW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned TmoW  = $clog2(TIMEOUT + 1);
    localparam logic [WaitW-1:0] WaitMax  = WaitW'(STARVE_LIMIT);
    localparam logic [TmoW-1:0]  TmoLast  = TmoW'(TIMEOUT - 1);
    localparam logic [2:0]       MaskWord = 3'b010;

    typedef enum logic [1:0] {StIdle, StServeD, StServeI} state_e;

    state_e            state_q, state_d;
    logic [WaitW-1:0]  i_wait_q, i_wait_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic [31:0]       addr_q, addr_d, wdata_q, wdata_d;
    logic [2:0]        mask_q, mask_d;
    logic              we_q, we_d;
    logic              i_ack_q, i_ack_d, d_ack_q, d_ack_d;
    logic [31:0]       i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic              tmo_err_q, tmo_err_d;
    logic              i_elig, d_elig, grant_i, grant_d, done;
    logic [31:0]       done_data;

    // A port whose ack is high this cycle is still holding req from the finished access.
    assign i_elig = i_req && !i_ack_q;
    assign d_elig = d_req && !d_ack_q;

    always_comb begin
        state_d   = state_q;
        i_wait_d  = i_wait_q;
        tmo_d     = tmo_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mask_d    = mask_q;
        we_d      = we_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        tmo_err_d = tmo_err_q;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        done      = 1'b0;
        done_data = '0;

        unique case (state_q)
            StIdle: begin
                if (i_elig && (i_wait_q == WaitMax)) begin
                    grant_i = 1'b1;
                end else if (d_elig) begin
                    grant_d = 1'b1;
                end else if (i_elig) begin
                    grant_i = 1'b1;
                end
            end
            StServeD, StServeI: begin
                if (m_hit) begin
                    done      = 1'b1;
                    done_data = we_q ? '0 : m_rdata;
                end else if (tmo_q == TmoLast) begin
                    done      = 1'b1;
                    tmo_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (grant_d) begin
            state_d = StServeD;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            mask_d  = d_mask;
            we_d    = d_we;
            tmo_d   = '0;
        end else if (grant_i) begin
            state_d = StServeI;
            addr_d  = i_addr;
            wdata_d = '0;
            mask_d  = MaskWord;
            we_d    = 1'b0;
            tmo_d   = '0;
        end

        if (done) begin
            state_d = StIdle;
            if (state_q == StServeI) begin
                i_ack_d   = 1'b1;
                i_rdata_d = done_data;
            end else begin
                d_ack_d   = 1'b1;
                d_rdata_d = done_data;
            end
        end

        if (!i_req || grant_i) begin
            i_wait_d = '0;
        end else if (i_wait_q != WaitMax) begin
            i_wait_d = i_wait_q + WaitW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            i_wait_q  <= '0;
            tmo_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mask_q    <= '0;
            we_q      <= 1'b0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_wait_q  <= i_wait_d;
            tmo_q     <= tmo_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mask_q    <= mask_d;
            we_q      <= we_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    // Memory port is gated by busy so it reads as all-zero while idle.
    assign busy        = (state_q != StIdle);
    assign m_addr      = busy ? addr_q : '0;
    assign m_wdata     = busy ? wdata_q : '0;
    assign m_mask      = busy ? mask_q : '0;
    assign m_read      = busy && !we_q;
    assign m_write     = busy && we_q;
    assign i_ack       = i_ack_q;
    assign d_ack       = d_ack_q;
    assign i_rdata     = i_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized two-port traffic
// against a word-level memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [2:0]  d_mask = '0;
    logic        i_ack, d_ack, m_read, m_write, m_hit, busy, timeout_err;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
    logic [2:0]  m_mask;

    logic        auto_mem = 1'b0, man_hit = 1'b0, auto_hit = 1'b0, mon_en = 1'b0;
    logic [31:0] man_rdata = '0, auto_rdata = '0;
    int unsigned lat_max = 0;
    int          total = 0, bad = 0;
    bit          grant_log[$];
    logic [31:0] env_mem [logic [29:0]];
    logic [31:0] shadow [logic [29:0]];

    assign m_hit   = auto_mem ? auto_hit : man_hit;
    assign m_rdata = auto_mem ? auto_rdata : man_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_read(m_read), .m_write(m_write),
        .m_mask(m_mask), .m_rdata(m_rdata), .m_hit(m_hit),
        .busy(busy), .timeout_err(timeout_err)
    );

    function automatic logic [31:0] init_word(input logic [29:0] w);
        return {w[15:0] ^ 16'h5a5a, ~w[15:0]};
    endfunction

    function automatic logic [2:0] pick_mask(input int unsigned s);
        case (s)
            0: return 3'b000;
            1: return 3'b001;
            2: return 3'b010;
            3: return 3'b100;
            default: return 3'b101;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory environment: random hit latency, word-granular storage.
    int unsigned r_cnt = 0, r_lat = 0;
    bit          r_active = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (auto_mem && (m_read || m_write)) begin
                if (!r_active) begin
                    r_active = 1'b1;
                    r_cnt    = 0;
                    r_lat    = $urandom_range(0, lat_max);
                    grant_log.push_back(m_addr[12]);
                    total++;
                    if (!((d_req && m_addr === d_addr) || (i_req && m_addr === i_addr))) begin
                        bad++;
                        $display("FAIL grant_addr: m_addr=%h d_addr=%h i_addr=%h",
                                 m_addr, d_addr, i_addr);
                    end
                end else begin
                    r_cnt++;
                end
                auto_hit   = (r_cnt == r_lat);
                auto_rdata = env_mem.exists(m_addr[31:2]) ? env_mem[m_addr[31:2]]
                                                           : init_word(m_addr[31:2]);
                if (m_write) auto_rdata = $urandom;
                if (auto_hit && m_write) env_mem[m_addr[31:2]] = m_wdata;
            end else begin
                r_active = 1'b0;
                auto_hit = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                total++;
                if ((m_read && m_write) || (busy !== (m_read || m_write))) begin
                    bad++;
                    $display("FAIL port_excl: rd=%b wr=%b busy=%b want exclusive strobes",
                             m_read, m_write, busy);
                end
            end
        end
    end

    task automatic run_d(input int n, input int unsigned maxgap);
        for (int k = 0; k < n; k++) begin
            logic [31:0] exp;
            bit          got;
            if (k > 0) tick();
            repeat ($urandom_range(0, maxgap)) tick();
            d_we    = ($urandom_range(0, 2) == 0);
            d_addr  = $urandom_range(0, 255);
            d_wdata = $urandom;
            d_mask  = pick_mask($urandom_range(0, 4));
            d_req   = 1'b1;
            if (d_we) exp = '0;
            else exp = shadow.exists(d_addr[31:2]) ? shadow[d_addr[31:2]]
                                                   : init_word(d_addr[31:2]);
            got = 1'b0;
            for (int c = 0; c < 64 && !got; c++) begin
                @(negedge clk);
                if (d_ack) got = 1'b1;
            end
            total++;
            if (!got) begin
                bad++;
                $display("FAIL d_ack_wait: no d_ack within 64 cycles, want one");
            end else if (d_rdata !== exp) begin
                bad++;
                $display("FAIL d_rdata_rand: got %h want %h (we=%b addr=%h)",
                         d_rdata, exp, d_we, d_addr);
            end
            if (d_we) shadow[d_addr[31:2]] = d_wdata;
            d_req = 1'b0;
        end
    endtask

    task automatic run_i(input int n, input int unsigned maxgap);
        for (int k = 0; k < n; k++) begin
            logic [31:0] exp;
            bit          got;
            if (k > 0) tick();
            repeat ($urandom_range(0, maxgap)) tick();
            i_addr = 32'h1000 + $urandom_range(0, 255);
            i_req  = 1'b1;
            exp    = init_word(i_addr[31:2]);
            got    = 1'b0;
            for (int c = 0; c < 64 && !got; c++) begin
                @(negedge clk);
                if (i_ack) got = 1'b1;
            end
            total++;
            if (!got) begin
                bad++;
                $display("FAIL i_ack_wait: no i_ack within 64 cycles, want one");
            end else if (i_rdata !== exp) begin
                bad++;
                $display("FAIL i_rdata_rand: got %h want %h", i_rdata, exp);
            end
            i_req = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({m_read, m_write, i_ack, d_ack, busy, timeout_err, m_mask} !== 9'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 0",
                     {m_read, m_write, i_ack, d_ack, busy, timeout_err, m_mask});
        end
        total++;
        if ({m_addr, m_wdata, i_rdata, d_rdata} !== 128'b0) begin
            bad++;
            $display("FAIL reset_data: got %h %h %h %h want 0", m_addr, m_wdata, i_rdata, d_rdata);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_load();
        d_we = 1'b0; d_addr = 32'h10; d_mask = 3'b010; d_wdata = $urandom; d_req = 1'b1;
        @(negedge clk);
        total++;
        if (m_read !== 1'b0) begin
            bad++; $display("FAIL load_c0_read: got %b want 0", m_read);
        end
        tick();
        man_hit = 1'b1; man_rdata = 32'hDEADBEEF;
        @(negedge clk);
        total++;
        if ({m_read, m_addr, m_mask, d_ack} !== {1'b1, 32'h10, 3'b010, 1'b0}) begin
            bad++;
            $display("FAIL load_c1_port: got rd=%b addr=%h mask=%b ack=%b want 1 10 010 0",
                     m_read, m_addr, m_mask, d_ack);
        end
        tick();
        man_hit = 1'b0; man_rdata = $urandom;
        @(negedge clk);
        total++;
        if ({d_ack, m_read, d_rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL load_c2_ack: got ack=%b rd=%b data=%h want 1 0 deadbeef",
                     d_ack, m_read, d_rdata);
        end
        d_req = 1'b0;
        tick();
        @(negedge clk);
        total++;
        if ({d_ack, m_read, d_rdata} !== {1'b0, 1'b0, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL load_hold: got ack=%b rd=%b data=%h want 0 0 deadbeef",
                     d_ack, m_read, d_rdata);
        end
        tick();
    endtask

    task automatic test_store();
        d_we = 1'b1; d_addr = 32'h13; d_mask = 3'b000; d_wdata = 32'hAB; d_req = 1'b1;
        tick();
        man_hit = 1'b1; man_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        total++;
        if ({m_write, m_read, m_mask, m_wdata, m_addr} !== {2'b10, 3'b000, 32'hAB, 32'h13}) begin
            bad++;
            $display("FAIL store_port: got wr=%b rd=%b mask=%b wdata=%h addr=%h want 1 0 000 ab 13",
                     m_write, m_read, m_mask, m_wdata, m_addr);
        end
        tick();
        man_hit = 1'b0;
        @(negedge clk);
        total++;
        if ({d_ack, m_write, d_rdata} !== {2'b10, 32'h0}) begin
            bad++;
            $display("FAIL store_ack: got ack=%b wr=%b data=%h want 1 0 0", d_ack, m_write, d_rdata);
        end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        logic [31:0] da, ia, r1, r2;
        da = $urandom_range(0, 255); ia = 32'h1000 | $urandom_range(0, 255);
        r1 = $urandom; r2 = $urandom;
        d_we = 1'b0; d_addr = da; d_mask = 3'b101; d_req = 1'b1;
        i_addr = ia; i_req = 1'b1;
        tick();
        man_hit = 1'b1; man_rdata = r1;
        @(negedge clk);
        total++;
        if ({m_read, m_addr} !== {1'b1, da}) begin
            bad++; $display("FAIL cont_d_first: got rd=%b addr=%h want 1 %h", m_read, m_addr, da);
        end
        tick();
        man_hit = 1'b0;
        @(negedge clk);
        total++;
        if ({d_ack, i_ack, m_read, d_rdata} !== {3'b100, r1}) begin
            bad++;
            $display("FAIL cont_d_ack: got d=%b i=%b rd=%b data=%h want 1 0 0 %h",
                     d_ack, i_ack, m_read, d_rdata, r1);
        end
        d_req = 1'b0;
        tick();
        man_hit = 1'b1; man_rdata = r2;
        @(negedge clk);
        total++;
        if ({m_read, m_addr, m_mask, m_wdata} !== {1'b1, ia, 3'b010, 32'h0}) begin
            bad++;
            $display("FAIL cont_i_port: got rd=%b addr=%h mask=%b wdata=%h want 1 %h 010 0",
                     m_read, m_addr, m_mask, m_wdata, ia);
        end
        tick();
        man_hit = 1'b0;
        @(negedge clk);
        total++;
        if ({i_ack, d_ack, i_rdata, d_rdata} !== {2'b10, r2, r1}) begin
            bad++;
            $display("FAIL cont_i_ack: got i=%b d=%b idata=%h ddata=%h want 1 0 %h %h",
                     i_ack, d_ack, i_rdata, d_rdata, r2, r1);
        end
        i_req = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        auto_mem = 1'b1; lat_max = 0; mon_en = 1'b1;
        grant_log.delete();
        fork
            run_d(4, 0);
            run_i(4, 0);
        join
        tick();
        total++;
        if (grant_log.size() != 8) begin
            bad++; $display("FAIL starve_count: got %0d grants want 8", grant_log.size());
        end
        for (int k = 0; k < grant_log.size() && k < 8; k++) begin
            bit exp_i;
            exp_i = ((k % 2) == 1);
            total++;
            if (grant_log[k] !== exp_i) begin
                bad++; $display("FAIL starve_order: grant %0d is_i=%b want %b", k, grant_log[k], exp_i);
            end
        end
        auto_mem = 1'b0; mon_en = 1'b0;
    endtask

    task automatic test_timeout(input bit hit_last);
        logic [31:0] rd;
        rd = $urandom | 32'h1;
        man_hit = 1'b0;
        d_we = 1'b0; d_addr = $urandom_range(0, 255); d_mask = 3'b010; d_req = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 16 && hit_last) begin
                man_hit = 1'b1; man_rdata = rd;
            end
            @(negedge clk);
            total++;
            if ({d_ack, m_read} !== 2'b01) begin
                bad++;
                $display("FAIL tmo_wait: cycle %0d got ack=%b rd=%b want 0 1", c, d_ack, m_read);
            end
        end
        tick();
        man_hit = 1'b0;
        @(negedge clk);
        total++;
        if (hit_last && {d_ack, timeout_err, d_rdata} !== {2'b10, rd}) begin
            bad++;
            $display("FAIL tmo_hit_wins: got ack=%b err=%b data=%h want 1 0 %h",
                     d_ack, timeout_err, d_rdata, rd);
        end else if (!hit_last && {d_ack, timeout_err, d_rdata} !== {2'b11, 32'h0}) begin
            bad++;
            $display("FAIL tmo_abort: got ack=%b err=%b data=%h want 1 1 0",
                     d_ack, timeout_err, d_rdata);
        end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        auto_mem = 1'b1; lat_max = 3; mon_en = 1'b1;
        grant_log.delete();
        fork
            run_d(24, 2);
            run_i(24, 3);
        join
        tick();
        total++;
        if (grant_log.size() != 48 || timeout_err !== 1'b1) begin
            bad++;
            $display("FAIL rand_summary: got %0d grants err=%b want 48 1",
                     grant_log.size(), timeout_err);
        end
        auto_mem = 1'b0; mon_en = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        man_hit = 1'b0;
        d_we = 1'b0; d_addr = 32'h40; d_mask = 3'b010; d_req = 1'b1;
        tick();
        @(negedge clk);
        total++;
        if (m_read !== 1'b1) begin
            bad++; $display("FAIL rstmid_pre: got rd=%b want 1", m_read);
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if ({m_read, m_write, d_ack, i_ack, busy, timeout_err, d_rdata} !== 38'b0) begin
            bad++;
            $display("FAIL rstmid_async: got rd=%b wr=%b d=%b i=%b busy=%b err=%b data=%h want 0",
                     m_read, m_write, d_ack, i_ack, busy, timeout_err, d_rdata);
        end
        d_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if ({d_ack, busy} !== 2'b00) begin
                bad++; $display("FAIL rstmid_after: got ack=%b busy=%b want 0 0", d_ack, busy);
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_store();
        test_contention();
        test_starvation();
        test_timeout(1'b1);
        test_timeout(1'b0);
        test_random();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported data/cache memory between two requesters: instruction fetch (I, read-only) and the MEM stage (D, read/write with byte/half/word mask).
- Latches one request at a time and drives the downstream memory port from registers.
- Waits for the memory's `hit`, then returns read data with a one-cycle acknowledge.
- D has priority, with a starvation guard for I and a per-access timeout.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles I may be denied while requesting before it overrides D priority.
- TIMEOUT, 16: cycles an access waits for `m_hit` before it is aborted.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request, held until i_ack
- i_addr  in  32  fetch byte address
- i_ack  out  1  one-cycle completion pulse for I
- i_rdata  out  32  fetched word, valid while i_ack=1
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1=store, 0=load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_mask  in  3  access size/sign code (000 b, 001 h, 010 w, 100 bu, 101 hu)
- d_ack  out  1  one-cycle completion pulse for D
- d_rdata  out  32  load result, valid while d_ack=1; 0 for stores
- m_addr  out  32  memory address
- m_wdata  out  32  memory write data
- m_read  out  1  memory read strobe
- m_write  out  1  memory write strobe
- m_mask  out  3  memory mask
- m_rdata  in  32  memory read data
- m_hit  in  1  memory completion, sampled on rising clk
- busy  out  1  high in SERVE_I/SERVE_D
- timeout_err  out  1  sticky, set on any timeout

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, wait/timeout counters=0. All outputs 0 immediately, including m_read/m_write, i_ack, d_ack, rdata buses and timeout_err. An in-flight access is dropped and no ack is issued.
- States: IDLE, SERVE_D, SERVE_I.
- IDLE, eligibility: a port is eligible if its req=1 and its ack is not high this cycle. Requesters drop req in the ack cycle; req seen during ack is ignored.
- IDLE, arbitration:
  - If I is eligible and i_wait==STARVE_LIMIT, go to SERVE_I.
  - Else if D is eligible, go to SERVE_D.
  - Else if I is eligible, go to SERVE_I.
  - On entry to a SERVE state, latch addr/wdata/mask/we of the winner.
- Memory port drive: m_* are driven from the latched registers for the whole SERVE state.
  - I: m_read=1, m_mask=010, m_wdata=0.
  - D: m_read=!we, m_write=we.
  - m_* are 0 in IDLE.
- i_wait counter:
  - Increments, saturating at STARVE_LIMIT, each cycle i_req=1 and SERVE_I is not entered.
  - Clears when SERVE_I is entered or i_req=0.
- SERVE_x completion (m_hit=1 at a rising edge):
  - Register m_rdata into x_rdata (0 for stores).
  - Pulse x_ack for exactly the next cycle.
  - Return to IDLE.
  - Minimum latency is 3 cycles: req sampled in cycle 0, memory strobed in cycle 1 with m_hit=1, ack in cycle 2.
- Back-to-back: the next grant is evaluated in the ack cycle (IDLE). One access is in flight at most; the memory never sees m_read and m_write together.
- Timeout:
  - The timeout counter clears on SERVE entry and increments each SERVE cycle with m_hit=0.
  - When it reaches TIMEOUT: abort, pulse x_ack with x_rdata=0, set timeout_err, return to IDLE.
  - timeout_err clears only on reset.
- Simultaneous m_hit and timeout-reach in the same cycle: the hit wins; data is returned and timeout_err is not set.
- x_rdata holds its value after ack until the next completion of that port.

Test Plan:
- Reset mid-access: D load in SERVE_D with m_hit=0, assert reset=0 → m_read=0 and all acks 0 immediately; state=IDLE after release; no d_ack.
- Single load: d_req=1, d_we=0, d_addr=0x10, d_mask=010, memory returns 0xDEADBEEF with m_hit in cycle 1 → d_ack in cycle 2 with d_rdata=0xDEADBEEF; m_read high exactly cycle 1.
- Contention: i_req and d_req both asserted in cycle 0 → D granted first (m_addr=d_addr); I granted in the IDLE cycle after d_ack; i_ack returns m_rdata.
- Starvation: i_req held, d_req re-issued back-to-back, m_hit immediate → after i_wait reaches 4, I is granted before the next D request; i_wait returns to 0.
- Store: d_we=1, d_mask=000, d_addr=0x13, d_wdata=0xAB → m_write=1, m_read=0, m_mask=000, m_wdata=0xAB for one cycle; d_ack with d_rdata=0.
- Timeout: m_hit held 0 → d_ack after 16 SERVE cycles with d_rdata=0 and timeout_err=1. Same setup with m_hit=1 in the 16th cycle → data returned, timeout_err=0.
